spi_mem_ctrl: RTL and testbench
===============================

Name: spi_mem_ctrl

Overview:
Command decoder and memory sequencer behind the SPI slave. It consumes the slave's 10-bit rx_data/rx_valid words and owns a single-port byte memory. It returns read bytes to the slave on tx_data/tx_valid. The same memory port is shared with a host-side request port, and pending SPI commands always take priority over host requests.

Parameters:
ADDR_WIDTH, 8, memory address width; DEPTH = 2**ADDR_WIDTH
AUTO_INC, 0, when 1: wr_addr/rd_addr increment (mod DEPTH) after each data access

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
rx_data  in  10  command word from SPI slave; [9:8] opcode, [7:0] payload
rx_valid  in  1  word valid; level, may stay high many cycles
ss_n  in  1  SPI slave select (active-low), used to release tx_valid
tx_data  out  8  read byte to SPI slave
tx_valid  out  1  tx_data valid, held until released
host_req  in  1  host access request; held until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_WIDTH  host address
host_wdata  in  8  host write data
host_gnt  out  1  one-cycle pulse in the cycle the host access is performed
host_rdata  out  8  host read data
host_rvalid  out  1  one-cycle pulse, cycle after a granted host read

Behaviour:
- Reset values: tx_data=0, tx_valid=0, host_gnt=0, host_rdata=0, host_rvalid=0, wr_addr=0, rd_addr=0, pend=0, FSM=IDLE, rx_valid_q=0. Memory contents are not reset.
- Command capture: a new command is detected only on a rising edge of rx_valid (rx_valid=1 and rx_valid_q=0). On that edge, rx_data is latched into cmd_q and pend is set. Holding rx_valid high produces exactly one command.
- Opcodes:
  - 00: wr_addr <= payload. No memory access.
  - 01: mem[wr_addr] <= payload.
  - 10: rd_addr <= payload. No memory access.
  - 11: read mem[rd_addr] and return it on tx_data.
- FSM states: IDLE, EXEC, RESP.
  - IDLE -> EXEC when pend=1.
  - EXEC is one cycle. It performs the cmd_q operation and clears pend. Next state is RESP for opcode 11, otherwise IDLE.
  - RESP is one cycle. The memory read data is registered into tx_data and tx_valid is set. Next state is IDLE.
- Latency, with the rising edge sampled at cycle N:
  - EXEC occurs at N+1.
  - A write is visible to any read from N+2.
  - For opcode 11, tx_valid=1 and tx_data are valid from N+3.
- tx_valid release: tx_valid clears on the first cycle ss_n is sampled high, or when a new command is captured. tx_data holds its last value after release.
- tx_valid conflict: if RESP and ss_n=1 occur in the same cycle, the release wins (tx_valid=0) and tx_data is still updated.
- AUTO_INC=1: wr_addr increments after each opcode-01 EXEC and rd_addr after each opcode-11 EXEC. Both wrap from DEPTH-1 to 0. Opcodes 00/10 override the address and do not increment.
- Arbitration: the memory port is granted to the host only in a cycle where the FSM is IDLE, pend=0, and no rising edge is being captured in that cycle. In that cycle host_gnt=1 and the access is performed.
  - Host write: mem[host_addr] <= host_wdata.
  - Host read: host_rdata/host_rvalid appear the next cycle.
  - A host request waiting during SPI traffic is stalled and not dropped. It is granted the first eligible cycle.
- Read/write ordering: a host read in the cycle after an SPI write to the same address returns the new data. Same-cycle SPI/host port conflicts cannot occur.
- A new rising edge during EXEC/RESP is captured normally into cmd_q/pend. The prior command is not lost because EXEC has already consumed it.
- Reset mid-operation: rst aborts any pend/EXEC/RESP immediately. A pending command is discarded. No partial memory write occurs after rst asserts.

Test Plan:
1. Reset, then SPI 0x005 (wr_addr=0x05), then 0x1A5 (write 0xA5), 0x205, 0x3xx -> tx_valid=1, tx_data=0xA5 three cycles after the 0x3xx edge; ss_n high -> tx_valid=0 next cycle.
2. rx_valid held high 12 cycles with 0x1FF after wr_addr=0x10 -> exactly one write. A host read of 0x10 returns 0xFF with a single host_rvalid pulse.
3. host_req write 0x20<=0x3C continuously while an SPI 0x1xx command arrives -> host_gnt delayed until pend clear and FSM IDLE. The write lands exactly once, and the SPI write completes first.
4. AUTO_INC=1, wr_addr=0xFF, two 01 writes (0x11, 0x22) -> mem[0xFF]=0x11, mem[0x00]=0x22; rd_addr=0xFF plus two reads -> 0x11 then 0x22.
5. Opcode 11 issued with ss_n rising in the RESP cycle -> tx_valid stays 0 and tx_data=read byte.
6. Assert rst one cycle after an SPI 0x1xx edge (pend=1) -> target address unchanged, all outputs at reset values, FSM IDLE.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
// SPI command decoder and byte-memory sequencer; shares the single memory
// port with a host request port, SPI commands always winning arbitration.
module spi_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned AUTO_INC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  ss_n,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic                  host_gnt,
  output logic [7:0]            host_rdata,
  output logic                  host_rvalid
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic [1:0] {OP_SET_WA, OP_WRITE, OP_SET_RA, OP_READ} op_t;

  state_t                  state, state_nxt;
  logic                    rx_valid_q;
  logic                    pend;
  logic [9:0]              cmd_q;
  logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
  logic [7:0]              rd_byte_q;
  logic [7:0]              mem [DEPTH];

  logic                    rise;
  logic                    exec;
  op_t                     op;
  logic [7:0]              payload;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [7:0]              mem_wdata;

  assign rise    = rx_valid & ~rx_valid_q;
  assign op      = op_t'(cmd_q[9:8]);
  assign payload = cmd_q[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend) state_nxt = EXEC;
      EXEC:    state_nxt = (op == OP_READ) ? RESP : IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exec      = (state == EXEC);
    host_gnt  = host_req & ~rst & (state == IDLE) & ~pend & ~rise;
    mem_we    = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    if (exec) begin
      mem_addr  = (op == OP_WRITE) ? wr_addr : rd_addr;
      mem_wdata = payload;
      mem_we    = (op == OP_WRITE);
    end else if (host_gnt) begin
      mem_we = host_we;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q  <= 1'b0;
      pend        <= 1'b0;
      cmd_q       <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_byte_q   <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (rise) begin
        cmd_q <= rx_data;
        pend  <= 1'b1;
      end else if (exec) begin
        pend <= 1'b0;
      end

      if (exec) begin
        case (op)
          OP_SET_WA: wr_addr <= ADDR_WIDTH'(payload);
          OP_WRITE:  if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_WIDTH'(1);
          OP_SET_RA: rd_addr <= ADDR_WIDTH'(payload);
          OP_READ: begin
            // Byte is captured in EXEC so the RESP stage is unaffected by the rd_addr increment.
            rd_byte_q <= mem[mem_addr];
            if (AUTO_INC != 0) rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
          default: ;
        endcase
      end

      if (state == RESP) tx_data <= rd_byte_q;
      if (rise || ss_n)        tx_valid <= 1'b0;
      else if (state == RESP)  tx_valid <= 1'b1;

      host_rvalid <= host_gnt & ~host_we;
      if (host_gnt && !host_we) host_rdata <= mem[mem_addr];
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: a plain-default and an AUTO_INC instance share stimulus;
// a timing/command model checks every cycle, directed vectors pin literal values.
module tb_spi_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       ss_n = 1'b0;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;

  logic [7:0] tx_data_o [2];
  logic [7:0] host_rdata_o [2];
  logic       tx_valid_o [2];
  logic       host_gnt_o [2];
  logic       host_rvalid_o [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.ADDR_WIDTH(8), .AUTO_INC(0)) u_dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .ss_n(ss_n),
    .tx_data(tx_data_o[0]), .tx_valid(tx_valid_o[0]),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_o[0]), .host_rdata(host_rdata_o[0]), .host_rvalid(host_rvalid_o[0])
  );

  spi_mem_ctrl #(.ADDR_WIDTH(8), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .ss_n(ss_n),
    .tx_data(tx_data_o[1]), .tx_valid(tx_valid_o[1]),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_o[1]), .host_rdata(host_rdata_o[1]), .host_rvalid(host_rvalid_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: per-instance memory/addresses/outputs, plus shared command timing.
  // A command captured at edge N executes at max(N+2, previous exec + 2, or +3 after a read);
  // the host port is blocked from the capture edge through exec (and the response edge of a read).
  typedef struct { int e; logic [9:0] w; } cmd_t;
  cmd_t       q[$];
  logic [7:0] m_mem [2][256];
  logic [7:0] m_wr [2], m_rd [2], m_txd [2], m_txpend [2], m_hrd [2];
  logic       m_txv [2], m_hrv [2];
  int         cyc = 0;
  int         blocked, last_p, tx_edge;
  bit         last_read, rxv_prev;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wr[d] = '0; m_rd[d] = '0; m_txd[d] = '0; m_txv[d] = 1'b0;
      m_hrd[d] = '0; m_hrv[d] = 1'b0; m_txpend[d] = '0;
    end
    blocked = -100; last_p = -100; tx_edge = -100;
    last_read = 1'b0; rxv_prev = 1'b0;
    q.delete();
  endtask

  task automatic apply_cmd(input logic [9:0] w, input int e);
    for (int d = 0; d < 2; d++) begin
      case (w[9:8])
        2'b00: m_wr[d] = w[7:0];
        2'b01: begin
          m_mem[d][m_wr[d]] = w[7:0];
          if (d == 1) m_wr[d] = m_wr[d] + 8'd1;
        end
        2'b10: m_rd[d] = w[7:0];
        default: begin
          m_txpend[d] = m_mem[d][m_rd[d]];
          if (d == 1) m_rd[d] = m_rd[d] + 8'd1;
        end
      endcase
    end
    if (w[9:8] == 2'b11) tx_edge = e + 1;
  endtask

  initial begin : cmp
    int e;
    bit rise;
    bit gexp;
    model_reset();
    forever begin
      @(negedge clk);
      e = cyc + 1;
      if (rst) model_reset();
      rise = !rst && rx_valid && !rxv_prev;
      gexp = !rst && host_req && (e > blocked) && !rise;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d_tx_data", d), tx_data_o[d], m_txd[d]);
        chk($sformatf("d%0d_tx_valid", d), tx_valid_o[d], m_txv[d]);
        chk($sformatf("d%0d_host_rdata", d), host_rdata_o[d], m_hrd[d]);
        chk($sformatf("d%0d_host_rvalid", d), host_rvalid_o[d], m_hrv[d]);
        chk($sformatf("d%0d_host_gnt", d), host_gnt_o[d], gexp);
      end
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          if (tx_edge == e) m_txd[d] = m_txpend[d];
          if (rise || ss_n)       m_txv[d] = 1'b0;
          else if (tx_edge == e)  m_txv[d] = 1'b1;
        end
        while (q.size() > 0 && q[0].e == e) apply_cmd(q.pop_front().w, e);
        for (int d = 0; d < 2; d++) begin
          m_hrv[d] = 1'b0;
          if (gexp) begin
            if (host_we) m_mem[d][host_addr] = host_wdata;
            else begin
              m_hrd[d] = m_mem[d][host_addr];
              m_hrv[d] = 1'b1;
            end
          end
        end
        if (rise) begin
          int p;
          p = last_p + (last_read ? 3 : 2);
          if (e + 2 > p) p = e + 2;
          q.push_back('{e: p, w: rx_data});
          last_p = p;
          last_read = (rx_data[9:8] == 2'b11);
          blocked = p + (last_read ? 1 : 0);
        end
        rxv_prev = rx_valid;
      end
      cyc++;
    end
  end

  task automatic spi(input logic [9:0] w, input int hold);
    @(posedge clk); #2 rx_data = w; rx_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #2 rx_valid = 1'b0;
  endtask

  task automatic spi_run(input logic [9:0] w);
    spi(w, 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] wd);
    int n;
    @(posedge clk); #2 host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (host_gnt_o[0]) break;
      n++;
      if (n > 50) begin
        chk("host_gnt_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #2 host_req = 1'b0;
  endtask

  task automatic chk_tx(input string name, input logic v, input logic [7:0] d0, input logic [7:0] d1);
    chk({name, "_v0"}, tx_valid_o[0], v);
    chk({name, "_v1"}, tx_valid_o[1], v);
    chk({name, "_d0"}, tx_data_o[0], d0);
    chk({name, "_d1"}, tx_data_o[1], d1);
  endtask

  initial begin : stim
    int n;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_tx("reset_tx", 1'b0, 8'h00, 8'h00);
    chk("reset_hrv", host_rvalid_o[0], 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) host_op(1'b1, 8'(i), 8'(i) ^ 8'h5A);

    // 1: basic write/read and release on ss_n
    spi_run(10'h005); spi_run(10'h1A5); spi_run(10'h205);
    spi(10'h300, 1);
    repeat (3) @(posedge clk);
    #2 chk_tx("t1_read", 1'b1, 8'hA5, 8'hA5);
    ss_n = 1'b1;
    @(posedge clk);
    #2 chk_tx("t1_release", 1'b0, 8'hA5, 8'hA5);
    ss_n = 1'b0;

    // 2: held rx_valid gives a single write
    spi_run(10'h010);
    spi(10'h1FF, 12);
    repeat (4) @(posedge clk);
    host_op(1'b0, 8'h10, 8'h00);
    chk("t2_hrd0", host_rdata_o[0], 8'hFF);
    chk("t2_hrd1", host_rdata_o[1], 8'hFF);
    chk("t2_hrv", host_rvalid_o[0], 1'b1);
    @(posedge clk);
    #2 chk("t2_hrv_pulse", host_rvalid_o[0], 1'b0);
    host_op(1'b0, 8'h11, 8'h00);
    chk("t2_next_addr1", host_rdata_o[1], 8'h4B);

    // 3: host write stalled behind an SPI write to the same address
    spi_run(10'h020);
    @(posedge clk);
    #2 rx_data = 10'h177; rx_valid = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h3C;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (host_gnt_o[0]) break;
    end
    chk("t3_gnt_wait", n, 4);
    @(posedge clk);
    #2 host_req = 1'b0; rx_valid = 1'b0;
    host_op(1'b0, 8'h20, 8'h00);
    chk("t3_final0", host_rdata_o[0], 8'h3C);
    chk("t3_final1", host_rdata_o[1], 8'h3C);

    // 4: address wrap with AUTO_INC
    spi_run(10'h0FF); spi_run(10'h111); spi_run(10'h122); spi_run(10'h2FF);
    spi(10'h300, 1);
    repeat (3) @(posedge clk);
    #2 chk_tx("t4_rd1", 1'b1, 8'h22, 8'h11);
    spi(10'h300, 1);
    repeat (3) @(posedge clk);
    #2 chk_tx("t4_rd2", 1'b1, 8'h22, 8'h22);
    host_op(1'b0, 8'h00, 8'h00);
    chk("t4_addr0_d0", host_rdata_o[0], 8'h5A);
    chk("t4_addr0_d1", host_rdata_o[1], 8'h22);

    // 5: ss_n high in the response cycle
    spi_run(10'h210);
    spi(10'h300, 1);
    @(posedge clk);
    @(posedge clk);
    #2 ss_n = 1'b1;
    @(posedge clk);
    #2 chk_tx("t5_conflict", 1'b0, 8'hFF, 8'hFF);
    ss_n = 1'b0;

    // 6: reset while a write is pending
    spi_run(10'h040);
    @(posedge clk);
    #2 rx_data = 10'h1EE; rx_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1; rx_valid = 1'b0;
    #1;
    chk_tx("t6_rst", 1'b0, 8'h00, 8'h00);
    chk("t6_hrd0", host_rdata_o[0], 8'h00);
    chk("t6_hrd1", host_rdata_o[1], 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    host_op(1'b0, 8'h40, 8'h00);
    chk("t6_untouched0", host_rdata_o[0], 8'h1A);
    chk("t6_untouched1", host_rdata_o[1], 8'h1A);
    spi_run(10'h1BB);
    host_op(1'b0, 8'h00, 8'h00);
    chk("t6_wraddr0", host_rdata_o[0], 8'hBB);
    chk("t6_wraddr1", host_rdata_o[1], 8'hBB);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    bad++;
    $display("FAIL watchdog act=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
